// File: rtl/seqdet_pkg.sv
// Shared definitions for the serial pattern detector: fill-counter width and overlap modes.
// No datapath here; no latency or flow control of its own.
package seqdet_pkg;

    localparam int OVL_RESTART = 0;
    localparam int OVL_ALLOW   = 1;

    // FILL must represent 0..n inclusive.
    function automatic int fill_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pattern_window.sv
// Serial shift window with saturating fill count; exposes post-shift values for same-edge compare.
// Registers update one edge after a shift request; no backpressure, a shift is always accepted.
module pattern_window
    import seqdet_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_shift,
    input  logic                 i_clr,
    input  logic                 i_x,
    output logic [N-1:0]         o_win_nxt,
    output logic [fill_w(N)-1:0] o_fill_nxt,
    output logic [fill_w(N)-1:0] o_fill
);

    localparam int             FW        = fill_w(N);
    localparam logic [FW-1:0]  FILL_FULL = FW'(N);

    logic [N-1:0]  r_win;
    logic [FW-1:0] r_fill;

    assign o_win_nxt  = {r_win[N-2:0], i_x};
    assign o_fill_nxt = (r_fill == FILL_FULL) ? r_fill : r_fill + FW'(1);
    assign o_fill     = r_fill;

    // Clear only touches the count; window bits survive so a restart simply needs N new samples.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_win  <= '0;
            r_fill <= '0;
        end else begin
            if (i_shift) begin
                r_win <= o_win_nxt;
            end
            if (i_clr) begin
                r_fill <= '0;
            end else if (i_shift) begin
                r_fill <= o_fill_nxt;
            end
        end
    end

endmodule

// File: rtl/pattern_detector.sv
// Serial pattern detector: compares the post-shift window against a loadable pattern, counts matches.
// Y is registered one edge after the completing sample; no backpressure, every EN sample is consumed.
module pattern_detector
    import seqdet_pkg::*;
#(
    parameter int           N           = 4,
    parameter logic [N-1:0] PAT_DEFAULT = '0,
    parameter int           OVERLAP     = OVL_ALLOW,
    parameter int           CNT_W       = 8
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 EN,
    input  logic                 X,
    input  logic                 LOAD,
    input  logic [N-1:0]         PAT_IN,
    output logic                 Y,
    output logic [fill_w(N)-1:0] FILL,
    output logic [CNT_W-1:0]     MATCH_CNT,
    output logic                 CNT_SAT
);

    localparam int               FW        = fill_w(N);
    localparam logic [FW-1:0]    FILL_FULL = FW'(N);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [N-1:0]     r_pat;
    logic             r_y;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sat;

    logic             w_shift;
    logic             w_clr;
    logic             w_match;
    logic [N-1:0]     w_win_nxt;
    logic [FW-1:0]    w_fill_nxt;
    logic [FW-1:0]    w_fill;

    // LOAD wins over EN, so a sample arriving with LOAD is dropped.
    assign w_shift = EN && !LOAD;
    assign w_match = w_shift && (w_win_nxt == r_pat) && (w_fill_nxt == FILL_FULL);
    assign w_clr   = LOAD || (w_match && (OVERLAP == OVL_RESTART));

    pattern_window #(
        .N (N)
    ) u_window (
        .i_clk      (CLK),
        .i_rst      (RESET),
        .i_shift    (w_shift),
        .i_clr      (w_clr),
        .i_x        (X),
        .o_win_nxt  (w_win_nxt),
        .o_fill_nxt (w_fill_nxt),
        .o_fill     (w_fill)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_pat <= PAT_DEFAULT;
            r_y   <= 1'b0;
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else begin
            r_y <= w_match;
            if (LOAD) begin
                r_pat <= PAT_IN;
            end
            // Saturation flag rises on the match that reaches all-ones, then sticks.
            if (w_match) begin
                if (r_cnt != CNT_MAX) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                if (r_cnt >= CNT_MAX - CNT_W'(1)) begin
                    r_sat <= 1'b1;
                end
            end
        end
    end

    assign Y         = r_y;
    assign FILL      = w_fill;
    assign MATCH_CNT = r_cnt;
    assign CNT_SAT   = r_sat;

endmodule

// File: tb/tb_pattern_detector.sv
// Scoreboard bench: three detector variants share stimulus and are checked against a sample-log model.
module tb_pattern_detector;

    logic       CLK;
    logic       RESET;
    logic       EN;
    logic       X;
    logic       LOAD;
    logic [3:0] PAT_IN;

    logic       y0, y1, y2;
    logic [2:0] fill0, fill1, fill2;
    logic [7:0] cnt0, cnt1;
    logic [1:0] cnt2;
    logic       sat0, sat1, sat2;

    pattern_detector dut_ovl (
        .CLK(CLK), .RESET(RESET), .EN(EN), .X(X), .LOAD(LOAD), .PAT_IN(PAT_IN),
        .Y(y0), .FILL(fill0), .MATCH_CNT(cnt0), .CNT_SAT(sat0)
    );

    pattern_detector #(.OVERLAP(0)) dut_rst (
        .CLK(CLK), .RESET(RESET), .EN(EN), .X(X), .LOAD(LOAD), .PAT_IN(PAT_IN),
        .Y(y1), .FILL(fill1), .MATCH_CNT(cnt1), .CNT_SAT(sat1)
    );

    pattern_detector #(.CNT_W(2)) dut_c2 (
        .CLK(CLK), .RESET(RESET), .EN(EN), .X(X), .LOAD(LOAD), .PAT_IN(PAT_IN),
        .Y(y2), .FILL(fill2), .MATCH_CNT(cnt2), .CNT_SAT(sat2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [2:0]      y;
        logic [2:0]      sat;
        logic [2:0][2:0] fill;
        logic [2:0][7:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: log of every accepted sample; each variant remembers where its window restarted.
    bit       samples[$];
    int       start_idx[3];
    int       cnt_m[3];
    bit       sat_m[3];
    bit       y_m[3];
    logic [3:0] pat_m;
    int       cmax[3] = '{255, 255, 3};
    int       ovl[3]  = '{1, 0, 1};

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
        end
    endtask

    task automatic step(input logic rst, input logic en, input logic x,
                        input logic ld, input logic [3:0] pat);
        exp_t e;
        int   f;
        RESET  = rst;
        EN     = en;
        X      = x;
        LOAD   = ld;
        PAT_IN = pat;
        @(posedge CLK);
        if (rst) begin
            pat_m = 4'b0000;
            for (int i = 0; i < 3; i++) begin
                start_idx[i] = samples.size();
                cnt_m[i] = 0;
                sat_m[i] = 1'b0;
                y_m[i]   = 1'b0;
            end
        end else if (ld) begin
            pat_m = pat;
            for (int i = 0; i < 3; i++) begin
                start_idx[i] = samples.size();
                y_m[i] = 1'b0;
            end
        end else if (en) begin
            samples.push_back(x);
            for (int i = 0; i < 3; i++) begin
                bit hit;
                hit = (samples.size() - start_idx[i]) >= 4;
                for (int k = 0; k < 4; k++) begin
                    if (hit && (samples[samples.size() - 4 + k] != pat_m[3 - k])) hit = 1'b0;
                end
                y_m[i] = hit;
                if (hit) begin
                    if (cnt_m[i] < cmax[i]) cnt_m[i]++;
                    if (cnt_m[i] == cmax[i]) sat_m[i] = 1'b1;
                    if (ovl[i] == 0) start_idx[i] = samples.size();
                end
            end
        end else begin
            for (int i = 0; i < 3; i++) y_m[i] = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            f = samples.size() - start_idx[i];
            if (f > 4) f = 4;
            e.y[i]    = y_m[i];
            e.sat[i]  = sat_m[i];
            e.fill[i] = 3'(f);
            e.cnt[i]  = 8'(cnt_m[i]);
        end
        sb.push_back(e);
        #1;
    endtask

    // Monitor: outputs are valid after every edge; compare whenever an expectation is pending.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("y_ovl",    8'(y0),    8'(e.y[0]));
                chk("fill_ovl", 8'(fill0), 8'(e.fill[0]));
                chk("cnt_ovl",  cnt0,      e.cnt[0]);
                chk("sat_ovl",  8'(sat0),  8'(e.sat[0]));
                chk("y_rst",    8'(y1),    8'(e.y[1]));
                chk("fill_rst", 8'(fill1), 8'(e.fill[1]));
                chk("cnt_rst",  cnt1,      e.cnt[1]);
                chk("sat_rst",  8'(sat1),  8'(e.sat[1]));
                chk("y_c2",     8'(y2),    8'(e.y[2]));
                chk("fill_c2",  8'(fill2), 8'(e.fill[2]));
                chk("cnt_c2",   8'(cnt2),  e.cnt[2]);
                chk("sat_c2",   8'(sat2),  8'(e.sat[2]));
            end
        end
    end

    initial begin
        logic [3:0] rp;
        RESET = 1'b1; EN = 1'b0; X = 1'b0; LOAD = 1'b0; PAT_IN = 4'b0000;
        pat_m = 4'b0000;

        // Default pattern 0000: five zeros.
        step(1, 0, 0, 0, 4'h0);
        step(1, 1, 1, 1, 4'hF);
        repeat (5) step(0, 1, 0, 0, 4'h0);
        step(0, 0, 1, 0, 4'h0);

        // Load 1011, feed it, then LOAD and EN together.
        step(0, 0, 1, 1, 4'b1011);
        step(0, 1, 1, 0, 4'h0);
        step(0, 1, 0, 0, 4'h0);
        step(0, 1, 1, 0, 4'h0);
        step(0, 1, 1, 0, 4'h0);
        step(0, 1, 1, 1, 4'b1011);
        step(0, 0, 0, 0, 4'h0);

        // EN toggling over 8 cycles with X=0; X high while EN low must be ignored.
        step(1, 0, 0, 0, 4'h0);
        for (int i = 0; i < 8; i++) step(0, (i % 2) == 0, (i % 2) == 1, 0, 4'h0);

        // Five matches to saturate the 2-bit counter, then reset.
        step(1, 0, 0, 0, 4'h0);
        repeat (8) step(0, 1, 0, 0, 4'h0);
        step(1, 0, 0, 0, 4'h0);
        step(0, 0, 0, 0, 4'h0);

        // Reset in the middle of a partial match.
        repeat (3) step(0, 1, 0, 0, 4'h0);
        step(1, 0, 0, 0, 4'h0);
        step(0, 1, 0, 0, 4'h0);
        step(0, 0, 0, 0, 4'h0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            rp = 4'($urandom_range(0, 15));
            step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
                 1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0, rp);
        end

        repeat (2) @(negedge CLK);
        #1;
        chk("drain", 8'(sb.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pattern_detector.md
PATTERN_DETECTOR -- requirements
Module: pattern_detector

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning pattern length in bits (legal 2..16).
REQ-002 The block SHALL have parameter PAT_DEFAULT, default 4'b0000, meaning the N-bit pattern loaded at reset.
REQ-003 The block SHALL have parameter OVERLAP, default 1, meaning overlapping matches are allowed (1) or the window restarts after each match (0).
REQ-004 The block SHALL have parameter CNT_W, default 8, meaning the match counter width.
REQ-005 The block SHALL have port CLK  input  1  system clock; all state updates on the rising edge.
REQ-006 The block SHALL have port RESET  input  1  reset, synchronous and active-high.
REQ-007 The block SHALL have port EN  input  1  X is a valid serial sample this cycle.
REQ-008 The block SHALL have port X  input  1  serial data bit.
REQ-009 The block SHALL have port LOAD  input  1  replace the active pattern with PAT_IN.
REQ-010 The block SHALL have port PAT_IN  input  N  new pattern; bit N-1 is compared with the oldest sample.
REQ-011 The block SHALL have port Y  output  1  registered one-cycle match pulse.
REQ-012 The block SHALL have port FILL  output  clog2(N+1)  count of valid samples in the window, saturating at N.
REQ-013 The block SHALL have port MATCH_CNT  output  CNT_W  number of matches since reset.
REQ-014 The block SHALL have port CNT_SAT  output  1  sticky flag; MATCH_CNT has saturated.

Function
REQ-015 On each edge with EN=1 and LOAD=0, the window SHALL shift left with X entering bit 0, and FILL SHALL increment, saturating at N.
REQ-016 On each edge with EN=0 and LOAD=0, the window and FILL SHALL hold.
REQ-017 A match SHALL be defined as: the post-shift window equals the active pattern AND the post-increment FILL equals N; it is evaluated only on EN=1 edges.
REQ-018 On a match edge, Y SHALL be registered to 1, giving latency of one edge from the completing sample; on every other edge Y SHALL be 0.
REQ-019 With OVERLAP=1, FILL SHALL remain at N after a match, so consecutive matching samples give back-to-back Y pulses.
REQ-020 With OVERLAP=0, FILL SHALL be cleared to 0 on the match edge, so the next match requires N fresh samples.
REQ-021 On a match edge, MATCH_CNT SHALL increment by 1; at all-ones it SHALL hold and CNT_SAT SHALL set.
REQ-022 CNT_SAT SHALL remain set until RESET.
REQ-023 A LOAD=1 edge SHALL latch PAT_IN as the active pattern, clear FILL to 0, and force Y to 0.
REQ-024 On a LOAD=1 edge, the window contents and MATCH_CNT SHALL be retained.
REQ-025 When LOAD=1 and EN=1 on the same edge, LOAD SHALL win and the sample SHALL be discarded.
REQ-026 X SHALL be ignored whenever EN=0, including on LOAD edges.

Reset
REQ-027 When RESET=1 at an edge, the block SHALL set: active pattern to PAT_DEFAULT, window to 0, FILL 0, Y 0, MATCH_CNT 0, CNT_SAT 0.
REQ-028 RESET SHALL take priority over LOAD and EN on the same edge.
REQ-029 A RESET asserted during a partially filled window SHALL discard that partial sequence; no Y pulse is produced for it.
REQ-030 All outputs SHALL be defined from the first edge after RESET is asserted.

Structure
REQ-031 A shared package seqdet_pkg SHALL hold the fill-width constant function and the OVERLAP mode encodings.
REQ-032 The shift window and saturating FILL counter SHALL be one sub-module, pattern_window.
REQ-033 The top level SHALL contain the compare logic, Y, the match counter, and pattern storage.
REQ-034 All outputs SHALL be driven directly from registers.

Verification
REQ-035 Scenario (N=4, defaults): RESET, then EN=1 with X = 0,0,0,0,0 -> Y pulses on the edges after samples 4 and 5, MATCH_CNT=2.
REQ-036 Scenario (OVERLAP=0): the same stimulus as REQ-035 -> Y pulses only after sample 4, FILL=1 after sample 5, MATCH_CNT=1.
REQ-037 Scenario: LOAD with PAT_IN=4'b1011, then X = 1,0,1,1 -> single Y pulse; a LOAD and EN on the same edge -> that sample is dropped and FILL=0.
REQ-038 Scenario: EN toggles 1,0,1,0 while X = 0 for 8 cycles -> 4 samples only; exactly one Y, on the 4th valid sample.
REQ-039 Scenario (CNT_W=2): 5 matches -> MATCH_CNT=3 with CNT_SAT=1 from the third match; RESET -> both 0.
REQ-040 Scenario: RESET asserted after 3 of 4 matching samples, then 1 more matching sample -> no Y, FILL=1.
